plot_arbiter: RTL and testbench
===============================

// Module: plot_arbiter
// PURPOSE
//  Shares the single VGA-adapter pixel-write port (oX/oY/oColour/oPlot) among N draw clients
//  (screen clear, hard-hat sprite, hit splash, score). Each client posts a filled-rectangle request.
//  The block grants one request at a time and rasterises it row-major, one pixel per clock.
//  Sits between the game FSM clients and the vga_adapter.
// PARAMETERS
//  N_REQ     3     number of requesting clients (2..8)
//  X_PIXELS  160   screen width; x coordinates 0..X_PIXELS-1
//  Y_PIXELS  120   screen height; y coordinates 0..Y_PIXELS-1
// PORTS
//  clk         in   1        system clock; all logic on rising edge
//  iResetn     in   1        synchronous, active-low reset
//  iReqValid   in   N_REQ    client i has a rectangle request pending
//  oReqReady   out  N_REQ    one-hot; request i accepted this cycle (valid&ready)
//  iReqX       in   8*N_REQ  client i top-left x (slice [8i+7:8i])
//  iReqY       in   7*N_REQ  client i top-left y
//  iReqW       in   8*N_REQ  client i width in pixels (0 = empty)
//  iReqH       in   7*N_REQ  client i height in pixels (0 = empty)
//  iReqColour  in   3*N_REQ  client i fill colour
//  oX/oY       out  8/7      pixel coordinate to adapter
//  oColour     out  3        pixel colour to adapter
//  oPlot       out  1        pixel write strobe
//  oBusy       out  1        high from accept until done pulse inclusive
//  oDone       out  1        one-cycle pulse: granted request finished
//  oDoneIdx    out  3        index of client whose request finished (valid with oDone)
// BEHAVIOUR
//  Reset (iResetn=0 at edge): all outputs 0, state IDLE, RR pointer 0; any request in flight
//   is abandoned with no done pulse, even mid-rectangle.
//  States: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: if any iReqValid, grant one, drive oReqReady[g]=1 this cycle, latch its X/Y/W/H/colour,
//   go RUN. Request fields are sampled only at accept; valid may drop before accept with no effect.
//  Arbitration: round-robin; search starts at (last granted + 1) mod N_REQ.
//  Clipping at latch (9-bit arithmetic): Weff = X>=X_PIXELS ? 0 : min(W, X_PIXELS-X);
//   Heff likewise with Y/Y_PIXELS. If Weff==0 or Heff==0: skip RUN, go straight to DONE.
//  RUN: first pixel (X,Y) with oPlot=1 on the cycle after accept; x increments to X+Weff-1,
//   then wraps to X with y+1; last pixel (X+Weff-1, Y+Heff-1); exactly Weff*Heff plot cycles.
//  DONE: oPlot=0, oDone=1, oDoneIdx=g for one cycle; no new grant this cycle; return IDLE.
//  Occupancy per request: 1 + Weff*Heff + 1 cycles; oReqReady never asserted outside IDLE.
//  oX/oY/oColour hold last values when oPlot=0; never reach off-screen coordinates.
// CONFIGURATION
//  FIXED_PRIORITY_EN defined: grant lowest-index valid client (client 0 = clear screen wins);
//   RR pointer unused. Undefined (default): round-robin as above.
// STRUCTURE
//  Package vga_draw_pkg: X_PIXELS/Y_PIXELS constants, colour width 3, state enum
//   (ST_IDLE, ST_RUN, ST_DONE), coordinate widths 8/7.
//  Sub-module rect_raster: load(x,y,w,h) + step -> x,y,last; owns the column/row counters.
//  Top holds arbiter, request latch, clip logic, FSM.
// TESTING
//  1: single req client1 X=10,Y=5,W=3,H=2,col=3'b100 -> accept, 6 plots (10,5)(11,5)(12,5)
//     (10,6)(11,6)(12,6), then oDone with oDoneIdx=1; total 8 cycles busy.
//  2: all 3 valid continuously, W=H=1 -> grants 0,1,2,0 (RR); with FIXED_PRIORITY_EN -> 0,0,0.
//  3: clip: X=158,Y=119,W=5,H=4 -> plots only (158,119),(159,119); X=200 -> zero plots, oDone.
//  4: W=0 -> accept, no oPlot, oDone next cycle.
//  5: iResetn low during RUN of a 160x120 clear -> next cycle all outputs 0, no oDone, next
//     request after reset granted from client 0.
//  6: valid asserted then dropped while block busy -> never accepted, no oReqReady pulse.

Source files
------------

// File: rtl/vga_draw_pkg.sv
// Shared screen geometry, field widths and draw-FSM state encoding for the
// VGA pixel-plot path.
package vga_draw_pkg;
  localparam int X_PIXELS = 160;
  localparam int Y_PIXELS = 120;
  localparam int COL_W    = 3;
  localparam int XW       = 8;
  localparam int YW       = 7;
  localparam int IDX_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;
endpackage

// File: rtl/plot_arbiter_rect_raster.sv
// Row-major rectangle walker: load a clipped rectangle, then each step advances
// one pixel; x/y hold the current pixel and last flags the bottom-right corner.
module rect_raster
  import vga_draw_pkg::*;
(
  input  logic          clk,
  input  logic          iResetn,
  input  logic          load,
  input  logic          step,
  input  logic [XW-1:0] load_x,
  input  logic [YW-1:0] load_y,
  input  logic [XW-1:0] load_w,
  input  logic [YW-1:0] load_h,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);
  logic [XW-1:0] x0, x_end;
  logic [YW-1:0] y_end;

  // Corner bounds; only meaningful after a load with nonzero width and height.
  always_ff @(posedge clk) begin
    if (load) begin
      x0    <= load_x;
      x_end <= load_x + load_w - XW'(1);
      y_end <= load_y + load_h - YW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!iResetn) begin
      x <= '0;
      y <= '0;
    end else if (load) begin
      x <= load_x;
      y <= load_y;
    end else if (step) begin
      if (x == x_end) begin
        x <= x0;
        y <= y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  assign last = (x == x_end) && (y == y_end);
endmodule

// File: rtl/plot_arbiter.sv
// Arbitrates N draw clients onto one VGA pixel-write port and rasterises each
// granted rectangle one pixel per clock. Define FIXED_PRIORITY_EN for
// lowest-index-wins arbitration instead of round-robin.
module plot_arbiter
  import vga_draw_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int X_PIXELS = vga_draw_pkg::X_PIXELS,
  parameter int Y_PIXELS = vga_draw_pkg::Y_PIXELS
) (
  input  logic                   clk,
  input  logic                   iResetn,
  input  logic [N_REQ-1:0]       iReqValid,
  output logic [N_REQ-1:0]       oReqReady,
  input  logic [XW*N_REQ-1:0]    iReqX,
  input  logic [YW*N_REQ-1:0]    iReqY,
  input  logic [XW*N_REQ-1:0]    iReqW,
  input  logic [YW*N_REQ-1:0]    iReqH,
  input  logic [COL_W*N_REQ-1:0] iReqColour,
  output logic [XW-1:0]          oX,
  output logic [YW-1:0]          oY,
  output logic [COL_W-1:0]       oColour,
  output logic                   oPlot,
  output logic                   oBusy,
  output logic                   oDone,
  output logic [IDX_W-1:0]       oDoneIdx
);
  state_t state, state_nx;
  logic              accept, any_valid, nonempty, last;
  logic [IDX_W-1:0]  grant_sel, grant_idx;
  logic [XW-1:0]     sel_x, sel_w, weff;
  logic [YW-1:0]     sel_y, sel_h, heff;
  logic [COL_W-1:0]  sel_c;

  // Width clipped against the right edge; 9-bit so X_PIXELS - X cannot wrap.
  function automatic logic [XW-1:0] clip_w(input logic [XW-1:0] x, input logic [XW-1:0] w);
    logic [XW:0] lim;
    if ({1'b0, x} >= (XW+1)'(X_PIXELS)) return '0;
    lim = (XW+1)'(X_PIXELS) - {1'b0, x};
    return ({1'b0, w} < lim) ? w : lim[XW-1:0];
  endfunction

  function automatic logic [YW-1:0] clip_h(input logic [YW-1:0] y, input logic [YW-1:0] h);
    logic [YW:0] lim;
    if ({1'b0, y} >= (YW+1)'(Y_PIXELS)) return '0;
    lim = (YW+1)'(Y_PIXELS) - {1'b0, y};
    return ({1'b0, h} < lim) ? h : lim[YW-1:0];
  endfunction

`ifndef FIXED_PRIORITY_EN
  logic [IDX_W-1:0] rr_ptr;
`endif

  always_comb begin
    int idx;
    any_valid = 1'b0;
    grant_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef FIXED_PRIORITY_EN
      idx = k;
`else
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
`endif
      if (!any_valid && iReqValid[idx]) begin
        any_valid = 1'b1;
        grant_sel = IDX_W'(idx);
      end
    end
  end

  assign sel_x    = iReqX[XW*grant_sel +: XW];
  assign sel_y    = iReqY[YW*grant_sel +: YW];
  assign sel_w    = iReqW[XW*grant_sel +: XW];
  assign sel_h    = iReqH[YW*grant_sel +: YW];
  assign sel_c    = iReqColour[COL_W*grant_sel +: COL_W];
  assign weff     = clip_w(sel_x, sel_w);
  assign heff     = clip_h(sel_y, sel_h);
  assign nonempty = (weff != '0) && (heff != '0);

  // Grant is combinational in IDLE and suppressed while reset is asserted.
  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    oReqReady = '0;
    oPlot     = 1'b0;
    oDone     = 1'b0;
    oDoneIdx  = '0;
    oBusy     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (iResetn && any_valid) begin
          accept    = 1'b1;
          oReqReady = {{(N_REQ-1){1'b0}}, 1'b1} << grant_sel;
          oBusy     = 1'b1;
          state_nx  = nonempty ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        oPlot = 1'b1;
        oBusy = 1'b1;
        if (last) state_nx = ST_DONE;
      end
      ST_DONE: begin
        oDone    = 1'b1;
        oDoneIdx = grant_idx;
        oBusy    = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!iResetn) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!iResetn) begin
      grant_idx <= '0;
      oColour   <= '0;
`ifndef FIXED_PRIORITY_EN
      rr_ptr    <= '0;
`endif
    end else if (accept) begin
      grant_idx <= grant_sel;
      if (nonempty) oColour <= sel_c;
`ifndef FIXED_PRIORITY_EN
      rr_ptr    <= (grant_sel == IDX_W'(N_REQ-1)) ? '0 : grant_sel + IDX_W'(1);
`endif
    end
  end

  // Empty rectangles never load, so oX/oY keep the last on-screen pixel.
  rect_raster u_raster (
    .clk     (clk),
    .iResetn (iResetn),
    .load    (accept && nonempty),
    .step    ((state == ST_RUN) && !last),
    .load_x  (sel_x),
    .load_y  (sel_y),
    .load_w  (weff),
    .load_h  (heff),
    .x       (oX),
    .y       (oY),
    .last    (last)
  );
endmodule

// File: tb/tb_plot_arbiter.sv
// Scoreboard bench for plot_arbiter: expected pixels and done events are queued
// at each accept and consumed as the DUT plots.
module tb_plot_arbiter;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           iResetn;
  logic [N-1:0]   iReqValid;
  logic [N-1:0]   oReqReady;
  logic [8*N-1:0] iReqX, iReqW;
  logic [7*N-1:0] iReqY, iReqH;
  logic [3*N-1:0] iReqColour;
  logic [7:0]     oX;
  logic [6:0]     oY;
  logic [2:0]     oColour;
  logic           oPlot, oBusy, oDone;
  logic [2:0]     oDoneIdx;

  always #5 clk = ~clk;

  plot_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .iResetn(iResetn), .iReqValid(iReqValid), .oReqReady(oReqReady),
    .iReqX(iReqX), .iReqY(iReqY), .iReqW(iReqW), .iReqH(iReqH), .iReqColour(iReqColour),
    .oX(oX), .oY(oY), .oColour(oColour), .oPlot(oPlot), .oBusy(oBusy),
    .oDone(oDone), .oDoneIdx(oDoneIdx)
  );

  typedef struct { int x; int y; int c; } pix_t;

  int   checks = 0, errors = 0;
  int   rx[N], ry[N], rw[N], rh[N], rc[N];
  pix_t pix_q[$];
  int   done_q[$];
  int   grant_log[$];
  int   model_ptr = 0;
  bit   model_busy = 1'b0;
  int   plot_count = 0, done_count = 0, ready2_count = 0;

  function automatic int model_grant(input logic [N-1:0] v);
    int i;
    for (int k = 0; k < N; k++) begin
`ifdef FIXED_PRIORITY_EN
      i = k;
`else
      i = (model_ptr + k) % N;
`endif
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    int g, act;
    pix_t p;
    if (oReqReady != '0) begin
      g = model_grant(iReqValid);
      act = -1;
      for (int i = N - 1; i >= 0; i--) if (oReqReady[i]) act = i;
      if (oReqReady[2]) ready2_count++;
      grant_log.push_back(act);
      checks++;
      if (model_busy) begin
        errors++;
        $display("FAIL ready_while_busy: oReqReady=%b, required 0", oReqReady);
      end
      checks++;
      if (g < 0 || oReqReady !== (N'(1) << g)) begin
        errors++;
        $display("FAIL grant: oReqReady=%b, required one-hot index %0d", oReqReady, g);
      end
      if (g >= 0) begin
        for (int yy = ry[g]; yy < ry[g] + rh[g]; yy++)
          for (int xx = rx[g]; xx < rx[g] + rw[g]; xx++)
            if (xx < 160 && yy < 120) begin
              p.x = xx; p.y = yy; p.c = rc[g];
              pix_q.push_back(p);
            end
        done_q.push_back(g);
        model_busy = 1'b1;
        model_ptr = (g + 1) % N;
      end
    end
    if (oPlot) begin
      plot_count++;
      checks++;
      if (pix_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_plot: got (%0d,%0d) col %0d, required no plot", oX, oY, oColour);
      end else begin
        p = pix_q.pop_front();
        if (int'(oX) !== p.x || int'(oY) !== p.y || int'(oColour) !== p.c) begin
          errors++;
          $display("FAIL pixel: got (%0d,%0d) col %0d, required (%0d,%0d) col %0d",
                   oX, oY, oColour, p.x, p.y, p.c);
        end
      end
    end
    if (oDone) begin
      done_count++;
      checks++;
      if (pix_q.size() != 0 || done_q.size() == 0) begin
        errors++;
        $display("FAIL done_early: %0d pixels pending, %0d dones pending, required 0 and 1",
                 pix_q.size(), done_q.size());
      end else begin
        g = done_q.pop_front();
        if (int'(oDoneIdx) !== g) begin
          errors++;
          $display("FAIL done_idx: got %0d, required %0d", oDoneIdx, g);
        end
      end
      model_busy = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input int x, input int y, input int w, input int h, input int c);
    rx[i] = x; ry[i] = y; rw[i] = w; rh[i] = h; rc[i] = c;
    iReqX[8*i +: 8]      = 8'(x);
    iReqY[7*i +: 7]      = 7'(y);
    iReqW[8*i +: 8]      = 8'(w);
    iReqH[7*i +: 7]      = 7'(h);
    iReqColour[3*i +: 3] = 3'(c);
  endtask

  task automatic flush_model();
    pix_q.delete(); done_q.delete();
    model_ptr = 0; model_busy = 1'b0;
  endtask

  task automatic do_reset();
    iResetn = 1'b0;
    tick(); tick();
    flush_model();
    iResetn = 1'b1;
  endtask

  task automatic wait_accept(input int i, input string name);
    int n = 0;
    @(negedge clk);
    while (!oReqReady[i] && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!oReqReady[i]) begin
      errors++;
      $display("FAIL %s_accept: no oReqReady[%0d] in 100 cycles, required accept", name, i);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((oBusy || pix_q.size() != 0 || done_q.size() != 0) && n < budget) begin tick(); n++; end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_idle: busy=%0d pending=%0d after %0d cycles, required idle",
               name, oBusy, pix_q.size(), budget);
    end
  endtask

  task automatic test_reset();
    iReqValid = '0;
    for (int i = 0; i < N; i++) set_req(i, 0, 0, 0, 0, 0);
    iResetn = 1'b0;
    tick(); tick();
    checks++;
    if ({oReqReady, oPlot, oDone, oBusy, oX, oY, oColour, oDoneIdx} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b plot=%b done=%b busy=%b x=%0d y=%0d c=%0d idx=%0d, required all 0",
               oReqReady, oPlot, oDone, oBusy, oX, oY, oColour, oDoneIdx);
    end
    iReqValid = '1;
    #2;
    checks++;
    if (oReqReady !== '0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_grant: ready=%b busy=%b, required 0 0", oReqReady, oBusy);
    end
    iReqValid = '0;
    flush_model();
    iResetn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int busy_cycles, p0;
    p0 = plot_count;
    set_req(1, 10, 5, 3, 2, 3'b100);
    iReqValid = 3'b010;
    wait_accept(1, "single");
    busy_cycles = oBusy ? 1 : 0;
    @(posedge clk); #1 iReqValid = '0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!oBusy) break;
      busy_cycles++;
    end
    checks++;
    if (busy_cycles !== 8) begin
      errors++;
      $display("FAIL single_busy: got %0d busy cycles, required 8", busy_cycles);
    end
    checks++;
    if (plot_count - p0 !== 6) begin
      errors++;
      $display("FAIL single_plots: got %0d, required 6", plot_count - p0);
    end
    checks++;
    if (oX !== 8'd12 || oY !== 7'd6 || oColour !== 3'b100) begin
      errors++;
      $display("FAIL single_hold: got (%0d,%0d) col %0d, required (12,6) col 4", oX, oY, oColour);
    end
    wait_idle(20, "single");
  endtask

  task automatic test_round_robin();
    int expg[4];
`ifdef FIXED_PRIORITY_EN
    expg = '{0, 0, 0, 0};
`else
    expg = '{0, 1, 2, 0};
`endif
    do_reset();
    set_req(0, 1, 1, 1, 1, 1);
    set_req(1, 2, 2, 1, 1, 2);
    set_req(2, 3, 3, 1, 1, 3);
    grant_log.delete();
    iReqValid = 3'b111;
    for (int n = 0; n < 100 && grant_log.size() < 4; n++) tick();
    iReqValid = '0;
    wait_idle(20, "rr");
    checks++;
    if (grant_log.size() < 4) begin
      errors++;
      $display("FAIL rr_count: got %0d grants, required 4", grant_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (grant_log[k] !== expg[k]) begin
          errors++;
          $display("FAIL rr_order[%0d]: got %0d, required %0d", k, grant_log[k], expg[k]);
        end
      end
    end
  endtask

  task automatic test_clip();
    int p0, d0;
    p0 = plot_count;
    set_req(0, 158, 119, 5, 4, 2);
    iReqValid = 3'b001;
    wait_accept(0, "clip");
    @(posedge clk); #1 iReqValid = '0;
    wait_idle(30, "clip");
    checks++;
    if (plot_count - p0 !== 2 || oX !== 8'd159 || oY !== 7'd119) begin
      errors++;
      $display("FAIL clip_edge: got %0d plots ending (%0d,%0d), required 2 ending (159,119)",
               plot_count - p0, oX, oY);
    end
    p0 = plot_count; d0 = done_count;
    set_req(0, 200, 10, 3, 3, 5);
    iReqValid = 3'b001;
    wait_accept(0, "clip_off");
    @(posedge clk); #1 iReqValid = '0;
    wait_idle(30, "clip_off");
    checks++;
    if (plot_count - p0 !== 0 || done_count - d0 !== 1 || oX !== 8'd159) begin
      errors++;
      $display("FAIL clip_offscreen: got %0d plots %0d dones x=%0d, required 0 plots 1 done x=159",
               plot_count - p0, done_count - d0, oX);
    end
  endtask

  task automatic test_zero_width();
    set_req(2, 20, 20, 0, 5, 1);
    iReqValid = 3'b100;
    wait_accept(2, "zero_w");
    @(posedge clk); #1 iReqValid = '0;
    @(negedge clk);
    checks++;
    if (oDone !== 1'b1 || oPlot !== 1'b0 || oDoneIdx !== 3'd2) begin
      errors++;
      $display("FAIL zero_w_done: done=%b plot=%b idx=%0d, required 1 0 2", oDone, oPlot, oDoneIdx);
    end
    wait_idle(10, "zero_w");
  endtask

  task automatic test_reset_mid();
    int d0;
    set_req(0, 0, 0, 160, 120, 7);
    iReqValid = 3'b001;
    wait_accept(0, "clear");
    @(posedge clk); #1 iReqValid = '0;
    repeat (50) tick();
    checks++;
    if (oPlot !== 1'b1) begin
      errors++;
      $display("FAIL clear_running: plot=%b, required 1", oPlot);
    end
    d0 = done_count;
    iResetn = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 40 + i, 40, 1, 1, i + 1);
    iReqValid = 3'b111;
    tick();
    checks++;
    if ({oReqReady, oPlot, oDone, oBusy, oX, oY, oColour, oDoneIdx} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: ready=%b plot=%b done=%b busy=%b x=%0d y=%0d c=%0d, required all 0",
               oReqReady, oPlot, oDone, oBusy, oX, oY, oColour);
    end
    flush_model();
    tick();
    checks++;
    if (done_count !== d0) begin
      errors++;
      $display("FAIL mid_reset_done: got %0d done pulses, required 0", done_count - d0);
    end
    grant_log.delete();
    iResetn = 1'b1;
    for (int n = 0; n < 20 && grant_log.size() < 1; n++) tick();
    iReqValid = '0;
    checks++;
    if (grant_log.size() < 1 || grant_log[0] !== 0) begin
      errors++;
      $display("FAIL post_reset_grant: got %0d grants first=%0d, required first 0",
               grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
    end
    wait_idle(20, "post_reset");
  endtask

  task automatic test_drop_while_busy();
    int r0;
    r0 = ready2_count;
    set_req(0, 30, 30, 4, 1, 6);
    iReqValid = 3'b001;
    wait_accept(0, "drop");
    @(posedge clk); #1 iReqValid = '0;
    set_req(2, 50, 50, 2, 2, 5);
    iReqValid = 3'b100;
    tick(); tick();
    iReqValid = '0;
    wait_idle(20, "drop");
    repeat (3) tick();
    checks++;
    if (ready2_count - r0 !== 0) begin
      errors++;
      $display("FAIL drop_ready: got %0d oReqReady[2] pulses, required 0", ready2_count - r0);
    end
  endtask

  initial begin
    iResetn = 1'b0;
    iReqValid = '0;
    iReqX = '0; iReqY = '0; iReqW = '0; iReqH = '0; iReqColour = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_clip();
    test_zero_width();
    test_reset_mid();
    test_drop_while_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
